// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, op encoding and result flags for adder_pipelined
package adder_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int STAGES_DEF = 4;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
  } flags_t;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: one registered SW-bit carry-chain stage of adder_pipelined
// clk, rst_n (sync, active-low), en_i (pipeline advance), valid_i/valid_o (stage valid),
// cin_i/cout_o (chain carry), cm_o (carry into this slice's MSB),
// x_i/x_o (operand a with finished sum bits spliced in), y_i/y_o (conditioned operand b plus sideband).
module adder_slice #(
  parameter int W  = 32,
  parameter int SW = 8,
  parameter int K  = 0,
  parameter int YW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic          cin_i,
  input  logic [W-1:0]  x_i,
  input  logic [YW-1:0] y_i,
  output logic          valid_o,
  output logic          cout_o,
  output logic          cm_o,
  output logic [W-1:0]  x_o,
  output logic [YW-1:0] y_o
);
  logic [SW:0] t;
  logic [W-1:0] x_d;
  logic cm_d;
  logic valid_q, c_q, cm_q;
  logic [W-1:0] x_q;
  logic [YW-1:0] y_q;
  always_comb begin
    t = {1'b0, x_i[K*SW +: SW]} + {1'b0, y_i[K*SW +: SW]} + {{SW{1'b0}}, cin_i};
    x_d = x_i;
    x_d[K*SW +: SW] = t[SW-1:0];
    cm_d = x_i[K*SW+SW-1] ^ y_i[K*SW+SW-1] ^ t[SW-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      c_q <= 1'b0;
      cm_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      c_q <= t[SW];
      cm_q <= cm_d;
      x_q <= x_d;
      y_q <= y_i;
    end
  end
  assign valid_o = valid_q;
  assign cout_o = c_q;
  assign cm_o = cm_q;
  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/adder_pipelined.sv
// adder_pipelined: STAGES-deep pipelined signed adder/subtractor with valid/ready flow control
// clk, rst_n (sync, active-low); in_valid/in_ready, a, b, carry_in, sub (0 add, 1 a-b);
// out_valid/out_ready, sum, carry_out, overflow, zero.
// ADDER_PIPELINED_SAT_EN adds input sat: clamp overflowing results to the signed max/min.
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
`ifdef ADDER_PIPELINED_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
`ifdef ADDER_PIPELINED_SAT_EN
  localparam int YW = WIDTH + 1;
`else
  localparam int YW = WIDTH;
`endif
  op_e op;
  flags_t f;
  logic v_w [STAGES+1];
  logic c_w [STAGES+1];
  logic cm_w [STAGES];
  logic [WIDTH-1:0] x_w [STAGES+1];
  logic [YW-1:0] y_w [STAGES+1];
  assign op = op_e'(sub);
  assign in_ready = !out_valid | out_ready;
  assign v_w[0] = in_valid;
  assign c_w[0] = (op == OP_SUB) ? 1'b1 : carry_in;
  assign x_w[0] = a;
`ifdef ADDER_PIPELINED_SAT_EN
  assign y_w[0] = {sat, (op == OP_SUB) ? ~b : b};
`else
  assign y_w[0] = (op == OP_SUB) ? ~b : b;
`endif
  for (genvar k = 0; k < STAGES; k++) begin : g_s
    adder_slice #(.W(WIDTH), .SW(SW), .K(k), .YW(YW)) u_slice (
      .clk(clk),
      .rst_n(rst_n),
      .en_i(in_ready),
      .valid_i(v_w[k]),
      .cin_i(c_w[k]),
      .x_i(x_w[k]),
      .y_i(y_w[k]),
      .valid_o(v_w[k+1]),
      .cout_o(c_w[k+1]),
      .cm_o(cm_w[k]),
      .x_o(x_w[k+1]),
      .y_o(y_w[k+1])
    );
  end
  always_comb begin
    f.carry_out = c_w[STAGES];
    f.overflow = cm_w[STAGES-1] ^ c_w[STAGES];
`ifdef ADDER_PIPELINED_SAT_EN
    // a carry out on overflow means both operands were negative
    sum = (y_w[STAGES][WIDTH] & f.overflow) ?
          (f.carry_out ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : x_w[STAGES];
`else
    sum = x_w[STAGES];
`endif
    // gated so that the flag reads 0 out of reset and on bubbles
    f.zero = out_valid & (sum == '0);
  end
  assign out_valid = v_w[STAGES];
  assign carry_out = f.carry_out;
  assign overflow = f.overflow;
  assign zero = f.zero;
endmodule

// File: tb/tb_adder_pipelined.sv
// tb_adder_pipelined: scoreboard bench for adder_pipelined against an arithmetic reference model
module tb_adder_pipelined;
  localparam int W = 32;
  localparam int S = 4;
`ifdef ADDER_PIPELINED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXS = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint MINS = -(64'sd1 <<< (W-1));
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, carry_in = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, carry_out, overflow, zero;
  logic [W-1:0] a = '0, b = '0, sum;
`ifdef ADDER_PIPELINED_SAT_EN
  logic sat = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] s;
    logic c;
    logic v;
    logic z;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, pct = 100, stall_n = 0, t_acc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  adder_pipelined #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .carry_in(carry_in),
    .sub(sub),
`ifdef ADDER_PIPELINED_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carry_out(carry_out),
    .overflow(overflow),
    .zero(zero)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, expv, $time);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                 input logic sb, input logic st);
    longint sx, sy, r;
    logic [63:0] u;
    exp_t e;
    sx = $signed(x);
    sy = $signed(y);
    r = sb ? sx - sy : sx + sy + (ci ? 64'sd1 : 64'sd0);
    u = {32'b0, x} + {32'b0, y} + {63'b0, ci};
    e.c = sb ? (x >= y) : u[W];
    e.v = (r > MAXS) || (r < MINS);
    e.s = r[W-1:0];
    if (st && e.v) e.s = (r > 0) ? MAXS[W-1:0] : MINS[W-1:0];
    e.z = (e.s == '0);
    return e;
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic tick_ready();
    if (stall_n > 0) begin
      out_ready = 1'b0;
      stall_n--;
    end else out_ready = ($urandom_range(0, 99) < pct);
  endtask
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb,
                      input logic st);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      a = x;
      b = y;
      carry_in = ci;
      sub = sb;
      in_valid = 1'b1;
`ifdef ADDER_PIPELINED_SAT_EN
      sat = st;
`endif
      tick_ready();
      #1;
      acc = in_ready;
      n++;
    end
    if (!acc) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    else begin
      t_acc = cyc;
      exp_q.push_back(model(x, y, ci, sb, st & SAT));
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      tick_ready();
    end
  endtask
  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      tick_ready();
      #1;
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) chk("out_timeout", {63'b0, out_valid}, 64'd1);
  endtask
  initial begin
    exp_t e;
    logic prev_stall = 1'b0, pc = 1'b0, pv = 1'b0, pz = 1'b0;
    logic [W-1:0] ps = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) prev_stall = 1'b0;
      else begin
        chk("in_ready_rule", {63'b0, in_ready}, {63'b0, !out_valid || out_ready});
        if (prev_stall) begin
          chk("hold_valid", {63'b0, out_valid}, 64'd1);
          chk("hold_sum", {32'b0, sum}, {32'b0, ps});
          chk("hold_flags", {61'b0, carry_out, overflow, zero}, {61'b0, pc, pv, pz});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("stray_out", {63'b0, out_valid}, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("sum", {32'b0, sum}, {32'b0, e.s});
            chk("carry_out", {63'b0, carry_out}, {63'b0, e.c});
            chk("overflow", {63'b0, overflow}, {63'b0, e.v});
            chk("zero", {63'b0, zero}, {63'b0, e.z});
          end
        end
        prev_stall = out_valid && !out_ready;
        ps = sum;
        pc = carry_out;
        pv = overflow;
        pz = zero;
      end
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_sum", {32'b0, sum}, 64'd0);
    chk("rst_carry_out", {63'b0, carry_out}, 64'd0);
    chk("rst_overflow", {63'b0, overflow}, 64'd0);
    chk("rst_zero", {63'b0, zero}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'd100000, 32'd200000, 1'b1, 1'b0, 1'b0);
    wait_out();
    chk("latency", 64'(cyc - t_acc), 64'(S));
    chk("sum_300001", {32'b0, sum}, 64'd300001);
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    send(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
    send(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    idle(8);
    send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) stall_n = 3;
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(8);
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {63'b0, in_ready}, 64'd1);
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("no_stale", {63'b0, out_valid}, 64'd0);
    end
    send(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    wait_out();
    chk("latency_after_rst", 64'(cyc - t_acc), 64'(S));
    pct = 70;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    pct = 100;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      idle(1);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_pipelined.md
ADDER_PIPELINED -- requirements
Module: adder_pipelined

Interface
- REQ-001: Parameter WIDTH, default 32, is the operand and result width in bits.
- REQ-002: Parameter STAGES, default 4, is the number of carry-chain pipeline stages; WIDTH SHALL be an integer multiple of STAGES, and STAGES SHALL be at least 1.
- REQ-003: clk  input  1  is the single clock; all state SHALL update on its rising edge.
- REQ-004: rst_n  input  1  is the reset: synchronous, active-low.
- REQ-005: in_valid  input  1  means the operand set is valid this cycle.
- REQ-006: in_ready  output  1  means the block accepts the operand set this cycle.
- REQ-007: a, b  input  WIDTH each  are signed two's-complement operands.
- REQ-008: carry_in  input  1  is the carry into bit 0 and is ignored when sub=1.
- REQ-009: sub  input  1  selects the operation: 0 = a+b+carry_in, 1 = a-b.
- REQ-010: out_valid  output  1  means the result is valid.
- REQ-011: out_ready  input  1  means downstream accepts the result.
- REQ-012: sum  output  WIDTH  is the result.
- REQ-013: carry_out  output  1  is the carry out of the MSB.
- REQ-014: overflow  output  1  flags signed overflow.
- REQ-015: zero  output  1  is asserted when sum equals 0.

Function
- REQ-016: Subtraction SHALL be computed as a + ~b + 1.
- REQ-017: The datapath SHALL split into STAGES slices of WIDTH/STAGES bits; slice k SHALL add in pipeline stage k using the carry registered from stage k-1.
- REQ-018: Operand bits not yet consumed SHALL be skewed forward, and finished sum bits SHALL be deskewed, so that each output presents one coherent result.
- REQ-019: Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall in between.
- REQ-020: With no backpressure, throughput SHALL be one result per cycle.
- REQ-021: overflow SHALL equal the carry into the MSB XOR carry_out.
- REQ-022: carry_out SHALL be the raw adder carry; for subtraction it is therefore the inverted borrow.
- REQ-023: in_ready SHALL equal !out_valid | out_ready.
- REQ-024: The whole pipeline SHALL advance only when in_ready=1; otherwise every stage SHALL hold, and the outputs SHALL stay stable while out_valid & !out_ready.
- REQ-025: Bubbles (in_valid=0 on an accepted cycle) SHALL propagate as invalid stages and SHALL NOT collapse.
- REQ-026: When out_ready is asserted, an input may be accepted and a result retired in the same cycle.
- REQ-027: A per-stage valid bit SHALL accompany the data in each stage; out_valid SHALL be the last stage's valid bit.

Reset
- REQ-028: While rst_n=0 at a clock edge, all stage valid bits, sum, carry_out, overflow and zero SHALL clear to 0, and out_valid SHALL be 0.
- REQ-029: A reset asserted mid-operation SHALL discard all in-flight operations, with no partial result emitted.
- REQ-030: in_ready SHALL be 1 in the first cycle after reset.

Configuration
- REQ-031: With ADDER_PIPELINED_SAT_EN defined, an extra input sat (1 bit) SHALL be pipelined alongside the data.
- REQ-032: With ADDER_PIPELINED_SAT_EN defined and sat=1 on an overflowing operation, sum SHALL clamp to the signed maximum (0x7FFF_FFFF when WIDTH=32) for positive overflow, or to the signed minimum for negative overflow; overflow SHALL still report 1.
- REQ-033: Without ADDER_PIPELINED_SAT_EN, the sat port and the clamp logic SHALL be absent and results SHALL always wrap.

Structure
- REQ-034: Package adder_pkg SHALL hold the WIDTH/STAGES defaults, the op encoding (OP_ADD=0, OP_SUB=1) and a result-flag struct (carry_out, overflow, zero).
- REQ-035: One sub-module, adder_slice, SHALL implement one registered slice: a SLICE_W-bit adder plus carry, valid and skew registers with the hold enable.

Verification
- REQ-036: a=100000, b=200000, carry_in=1, sub=0 -> after 4 cycles sum=300001, carry_out=0, overflow=0.
- REQ-037: a=0x80000000, b=0x7FFFFFFF, carry_in=1 -> sum=0x00000000, carry_out=1, overflow=0, zero=1.
- REQ-038: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1; with SAT_EN and sat=1 -> sum=0x7FFFFFFF, overflow=1.
- REQ-039: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, carry_out=0; sub=1, a=0x80000000, b=1 -> overflow=1.
- REQ-040: Stream 0x12345678+0x87654321 followed by 6 more back-to-back operations, holding out_ready=0 for 3 cycles mid-stream -> first sum=0x99999999; order and values preserved, outputs stable while stalled, in_ready=0 during the stall.
- REQ-041: Assert rst_n=0 for one cycle with 3 operations in flight -> out_valid stays 0 until the next new input has completed its 4 cycles, and no stale result appears.
